// File: rtl/brazo_pkg.sv
// Shared types and defaults for the arm's motion playback/record paths.
package brazo_pkg;

    // Playback FSM states; encoding is also what dbg_state reports.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // x-axis byte that terminates a recorded sequence.
    localparam logic [7:0] END_CODE_DEFAULT = 8'hFF;

    // 20 ms step at 50 MHz.
    localparam int DEFAULT_DWELL = 50_000_000 / 50;

    // Dwell counter width; wide enough for any practical dwell.
    localparam int TIMER_W = 32;

endpackage

// File: rtl/playback_sequencer_dwell_timer.sv
// Loadable down-counter that flags expiry at zero. Shared by playback and record.
module dwell_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Clear beats load beats decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/playback_sequencer.sv
// Recorded-motion playback: walks the servo ROM address bus, latches the three
// axis bytes and holds each step for a fixed dwell before fetching the next.
//
// Timing: IDLE->FETCH (address settles for a synchronous ROM) -> LATCH (bytes
// captured, step_valid pulses next cycle, dwell loaded with DWELL_CYCLES-3) ->
// HOLD (count to zero, then advance). FETCH+LATCH+HOLD add up to exactly
// DWELL_CYCLES cycles between step pulses. play=0 aborts to IDLE from anywhere
// and outranks enable=0, which freezes everything and masks step_valid.
module playback_sequencer
    import brazo_pkg::*;
#(
    parameter int             ADDR_W       = 8,
    parameter int             DATA_W       = 8,
    parameter int             DWELL_CYCLES = DEFAULT_DWELL,
    parameter logic [DATA_W-1:0] END_CODE  = DATA_W'(END_CODE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              play,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data_x,
    input  logic [DATA_W-1:0] rom_data_y,
    input  logic [DATA_W-1:0] rom_data_z,
    output logic [15:0]       data_out_x,
    output logic [15:0]       data_out_y,
    output logic [15:0]       data_out_z,
    output logic              step_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;
    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(DWELL_CYCLES - 3);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data_x;
    logic [15:0]       r_data_y;
    logic [15:0]       r_data_z;
    logic              r_step;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_step;
    logic              w_clear;
    logic              w_load;
    logic              w_dec;
    logic              w_expired;

    dwell_timer #(
        .W (TIMER_W)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_expired  (w_expired)
    );

    // Next-state, address and timer control; abort first, then pause, then FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        if (!play && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
            w_clear     = 1'b1;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    w_addr_nxt = '0;
                    if (play) w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    w_state_nxt = ST_LATCH;
                end
                ST_LATCH: begin
                    if (rom_data_x == END_CODE) begin
                        if (loop) begin
                            w_addr_nxt  = '0;
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_step      = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_dec = 1'b1;
                    if (w_expired) begin
                        if (r_addr == ADDR_MAX) begin
                            // Top of the ROM counts as end of sequence; never wrap.
                            if (loop) begin
                                w_addr_nxt  = '0;
                                w_state_nxt = ST_FETCH;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_addr_nxt  = r_addr + 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                end
            endcase
        end
    end

    // State, address and status flags; busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_step  <= w_step;
            r_busy  <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_LATCH) ||
                       (w_state_nxt == ST_HOLD);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Axis commands change only on a real step; aborts leave servos where they are.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_x <= '0;
            r_data_y <= '0;
            r_data_z <= '0;
        end else if (w_step) begin
            r_data_x <= 16'(rom_data_x);
            r_data_y <= 16'(rom_data_y);
            r_data_z <= 16'(rom_data_z);
        end
    end

    assign rom_address = r_addr;
    assign data_out_x  = r_data_x;
    assign data_out_y  = r_data_y;
    assign data_out_z  = r_data_z;
    assign step_valid  = r_step;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer with DWELL_CYCLES=8 and a synchronous ROM model.
module tb_playback_sequencer;

  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        play = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  rom_address;
  logic [7:0]  rd_x, rd_y, rd_z;
  logic [15:0] data_out_x, data_out_y, data_out_z;
  logic        step_valid, busy, done;
  logic [2:0]  dbg_state;

  logic [7:0]  mem_x [256];
  logic [7:0]  mem_y [256];
  logic [7:0]  mem_z [256];

  logic [23:0] exp_q [$];
  int          pulse_cyc [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    int         img;
    logic       lp;
    int         ncyc;
    int         pulses;
    logic       busy;
    logic       done;
    logic [7:0] addr;
    logic [7:0] x;
  } vec_t;

  vec_t vecs [7];

  playback_sequencer #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .DWELL_CYCLES (DWELL),
    .END_CODE     (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .play        (play),
    .loop        (loop),
    .rom_address (rom_address),
    .rom_data_x  (rd_x),
    .rom_data_y  (rd_y),
    .rom_data_z  (rd_z),
    .data_out_x  (data_out_x),
    .data_out_y  (data_out_y),
    .data_out_z  (data_out_z),
    .step_valid  (step_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter / synchronous ROM
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rd_x <= mem_x[rom_address];
    rd_y <= mem_y[rom_address];
    rd_z <= mem_z[rom_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard: every step pulse pops one expected {x,y,z}
  always @(negedge clk) begin
    if (rst && step_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("step_data", {data_out_x, data_out_y, data_out_z},
              {8'h00, e[23:16], 8'h00, e[15:8], 8'h00, e[7:0]});
      end
    end
  end

  task automatic load_image(input int img);
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 8'hFF;
      mem_y[i] = 8'h00;
      mem_z[i] = 8'h00;
      if (img == 2) begin
        mem_x[i] = (i == 255) ? 8'h55 : 8'(i);
        mem_y[i] = 8'(i + 1);
        mem_z[i] = 8'hA0 ^ 8'(i);
      end
    end
    if (img == 0) begin
      mem_x[0] = 8'd10; mem_y[0] = 8'd20; mem_z[0] = 8'd30;
      mem_x[1] = 8'd11; mem_y[1] = 8'd21; mem_z[1] = 8'd31;
    end
  endtask

  task automatic do_reset(input int img, input logic lp);
    rst = 1'b0;
    play = 1'b0;
    enable = 1'b1;
    loop = lp;
    load_image(img);
    repeat (2) @(negedge clk);
    exp_q.delete();
    pulse_cyc.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // reference walk of the ROM image: expected step sequence
  task automatic fill_queue(input int n, input logic lp);
    int a = 0;
    int pushed = 0;
    int iter = 0;
    while (pushed < n && iter < 4000) begin
      iter++;
      if (mem_x[a] == 8'hFF) begin
        if (!lp || mem_x[0] == 8'hFF) break;
        a = 0;
      end else begin
        exp_q.push_back({mem_x[a], mem_y[a], mem_z[a]});
        pushed++;
        if (a == 255) begin
          if (!lp) break;
          a = 0;
        end else begin
          a++;
        end
      end
    end
  endtask

  initial begin
    int c0;
    logic quiet;

    //         img lp  ncyc  pulses busy done addr   x
    vecs[0] = '{0, 0,    40,    2,  0,   1,   8'd2,   8'd11};
    vecs[1] = '{0, 1,    50,    6,  1,   0,   8'd1,   8'd11};
    vecs[2] = '{0, 0,     3,    1,  1,   0,   8'd0,   8'd10};
    vecs[3] = '{0, 0,     2,    0,  1,   0,   8'd0,   8'd0};
    vecs[4] = '{1, 0,    10,    0,  0,   1,   8'd0,   8'd0};
    vecs[5] = '{1, 1,    10,    0,  1,   0,   8'd0,   8'd0};
    vecs[6] = '{2, 0,  2100,  256,  0,   1,   8'd255, 8'h55};

    // reset state
    do_reset(0, 1'b0);
    #1;
    check("rst_addr", rom_address, 0);
    check("rst_data", {data_out_x, data_out_y, data_out_z}, 0);
    check("rst_flags", {step_valid, busy, done}, 0);
    check("rst_state", dbg_state, 0);

    // table-driven runs
    foreach (vecs[i]) begin
      do_reset(vecs[i].img, vecs[i].lp);
      fill_queue(vecs[i].pulses, vecs[i].lp);
      play = 1'b1;
      c0 = cyc;
      repeat (vecs[i].ncyc) @(negedge clk);
      #1;
      check($sformatf("v%0d_pulses", i), pulse_cyc.size(), vecs[i].pulses);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d_done", i), done, vecs[i].done);
      check($sformatf("v%0d_addr", i), rom_address, vecs[i].addr);
      check($sformatf("v%0d_x", i), data_out_x, {8'h00, vecs[i].x});
      check($sformatf("v%0d_q_left", i), exp_q.size(), 0);
      if (pulse_cyc.size() >= 1) check($sformatf("v%0d_latency", i), pulse_cyc[0] - c0, 3);
      if (pulse_cyc.size() >= 2) check($sformatf("v%0d_period", i), pulse_cyc[1] - pulse_cyc[0], DWELL);
    end

    // enable drop of 5 cycles mid-HOLD stretches the gap to 13
    do_reset(0, 1'b0);
    fill_queue(2, 1'b0);
    play = 1'b1;
    repeat (3) @(negedge clk);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (step_valid || !busy) quiet = 1'b0;
    end
    check("pause_quiet_busy", quiet, 1);
    enable = 1'b1;
    for (int k = 0; k < 20 && pulse_cyc.size() < 2; k++) begin
      @(negedge clk);
      #1;
    end
    check("pause_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() >= 2) check("pause_gap", pulse_cyc[1] - pulse_cyc[0], DWELL + 5);

    // play drop in HOLD of step 1, then restart from address 0
    do_reset(0, 1'b0);
    fill_queue(2, 1'b0);
    exp_q.push_back({8'd10, 8'd20, 8'd30});
    play = 1'b1;
    repeat (13) @(negedge clk);
    play = 1'b0;
    @(negedge clk);
    #1;
    check("abort_state", dbg_state, 0);
    check("abort_addr", rom_address, 0);
    check("abort_busy", busy, 0);
    check("abort_x_kept", data_out_x, 16'h000B);
    play = 1'b1;
    c0 = cyc;
    repeat (3) @(negedge clk);
    #1;
    check("replay_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() >= 3) check("replay_latency", pulse_cyc[2] - c0, 3);
    check("replay_x", data_out_x, 16'h000A);

    // async reset mid-FETCH of address 1
    do_reset(0, 1'b0);
    fill_queue(2, 1'b0);
    play = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    check("pre_rst_state", dbg_state, 1);
    check("pre_rst_addr", rom_address, 1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_data", {data_out_x, data_out_y, data_out_z}, 0);
    check("arst_addr_flags", {rom_address, step_valid, busy, done}, 0);
    play = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_state", dbg_state, 0);
    check("post_rst_flags", {busy, done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
